// File: rtl/rv_trap_ctrl_pkg.sv
// Shared definitions for the machine-mode trap controller: CSR addresses,
// field positions, cause codes, write masks and controller state encoding.
package rv_trap_ctrl_pkg;

  typedef enum logic [11:0] {
    CSR_ID_MSTATUS = 12'h300,
    CSR_ID_MIE     = 12'h304,
    CSR_ID_MEPC    = 12'h341,
    CSR_ID_MCAUSE  = 12'h342,
    CSR_ID_MIP     = 12'h344
  } csr_id_e;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MIX_MEI      = 11;
  localparam int MIX_MTI      = 7;

  typedef enum logic [3:0] {
    EXC_ILLEGAL = 4'd2,
    EXC_BREAK   = 4'd3,
    EXC_ECALL   = 4'd11
  } exc_code_e;

  typedef enum logic [3:0] {
    IRQ_TIMER = 4'd7,
    IRQ_EXT   = 4'd11
  } irq_code_e;

  typedef enum logic {
    ST_IDLE,
    ST_HOLDOFF
  } trap_state_e;

  localparam logic [31:0] MSTATUS_WMASK = 32'h0000_0088;
  localparam logic [31:0] MIE_WMASK     = 32'h0000_0880;
  localparam logic [31:0] MEPC_WMASK    = 32'hFFFF_FFFC;
  localparam logic [31:0] MCAUSE_WMASK  = 32'h8000_000F;

  function automatic logic [31:0] irq_mcause(irq_code_e code);
    return {1'b1, 27'b0, code};
  endfunction

endpackage

// File: rtl/rv_irq_sync.sv
// Multi-flop synchronizer for the asynchronous external interrupt level;
// every stage clears on reset so no stale level survives a reset.
module rv_irq_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/rv_trap_ctrl.sv
// Machine-mode trap/interrupt controller: owns mstatus/mie/mip/mepc/mcause,
// decides trap entry and mret. Optional macro URV_VECTORED_IRQ_EN vectors interrupts.
module rv_trap_ctrl
  import rv_trap_ctrl_pkg::*;
#(
  parameter logic [31:0] TRAP_VECTOR     = 32'h0000_0008,
  parameter int          IRQ_SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        x_stall_i,
  input  logic        x_kill_i,
  input  logic [31:0] x_pc_i,
  input  logic        d_is_csr_i,
  input  logic [11:0] d_csr_sel_i,
  input  logic [31:0] x_csr_write_value_i,
  input  logic        x_exception_i,
  input  logic [3:0]  x_exception_cause_i,
  input  logic        x_is_mret_i,
  input  logic        irq_i,
  input  logic        timer_tick_i,
  output logic        x_trap_o,
  output logic [31:0] x_trap_pc_o,
  output logic        x_mret_o,
  output logic [31:0] csr_mstatus_o,
  output logic [31:0] csr_mip_o,
  output logic [31:0] csr_mie_o,
  output logic [31:0] csr_mepc_o,
  output logic [31:0] csr_mcause_o
);

  trap_state_e state_q, state_d;
  logic [31:0] mstatus_q, mie_q, mepc_q, mcause_q;
  logic        mtip_q;
  logic        meip;
  logic [31:0] mip_val;
  logic        adv, irq_pend;
  logic        take_exc, take_irq, take_trap, take_mret, csr_wr;
  irq_code_e   irq_code;

  rv_irq_sync #(
    .STAGES (IRQ_SYNC_STAGES)
  ) u_irq_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (irq_i),
    .q_o   (meip)
  );

  assign mip_val = {20'b0, meip, 3'b0, mtip_q, 7'b0};

  assign adv       = !x_stall_i && !x_kill_i;
  assign irq_pend  = mstatus_q[MSTATUS_MIE] && ((mie_q & mip_val) != 32'b0) && (state_q == ST_IDLE);
  assign take_exc  = adv && x_exception_i;
  assign take_irq  = adv && !x_exception_i && irq_pend;
  assign take_trap = take_exc || take_irq;
  assign take_mret = adv && !take_trap && x_is_mret_i;
  // CSR writes only land when no trap or mret claims the cycle.
  assign csr_wr    = adv && !take_trap && !take_mret && d_is_csr_i;
  assign irq_code  = (mie_q[MIX_MEI] && meip) ? IRQ_EXT : IRQ_TIMER;

  assign x_trap_o = take_trap && !rst_i;
  assign x_mret_o = take_mret && !rst_i;

`ifdef URV_VECTORED_IRQ_EN
  assign x_trap_pc_o = (irq_pend && !x_exception_i)
                     ? TRAP_VECTOR + {26'b0, irq_code, 2'b00}
                     : TRAP_VECTOR;
`else
  assign x_trap_pc_o = TRAP_VECTOR;
`endif

  assign csr_mstatus_o = mstatus_q;
  assign csr_mie_o     = mie_q;
  assign csr_mip_o     = mip_val;
  assign csr_mepc_o    = mepc_q;
  assign csr_mcause_o  = mcause_q;

  // ---- controller state: holdoff after every trap or mret ----
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (adv) begin
      state_d = (take_trap || take_mret) ? ST_HOLDOFF : ST_IDLE;
    end
  end

  // ---- architectural registers ----
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mstatus_q <= '0;
      mie_q     <= '0;
      mepc_q    <= '0;
      mcause_q  <= '0;
      mtip_q    <= 1'b0;
    end else begin
      // A tick beats a same-cycle software clear of MTIP.
      if (timer_tick_i) begin
        mtip_q <= 1'b1;
      end else if (csr_wr && (d_csr_sel_i == CSR_ID_MIP)) begin
        mtip_q <= x_csr_write_value_i[MIX_MTI];
      end

      if (take_trap) begin
        mepc_q                  <= x_pc_i & MEPC_WMASK;
        mcause_q                <= take_irq ? irq_mcause(irq_code)
                                            : {28'b0, x_exception_cause_i};
        mstatus_q[MSTATUS_MPIE] <= mstatus_q[MSTATUS_MIE];
        mstatus_q[MSTATUS_MIE]  <= 1'b0;
      end else if (take_mret) begin
        mstatus_q[MSTATUS_MIE]  <= mstatus_q[MSTATUS_MPIE];
        mstatus_q[MSTATUS_MPIE] <= 1'b1;
      end else if (csr_wr) begin
        case (d_csr_sel_i)
          CSR_ID_MSTATUS: mstatus_q <= x_csr_write_value_i & MSTATUS_WMASK;
          CSR_ID_MIE:     mie_q     <= x_csr_write_value_i & MIE_WMASK;
          CSR_ID_MEPC:    mepc_q    <= x_csr_write_value_i & MEPC_WMASK;
          CSR_ID_MCAUSE:  mcause_q  <= x_csr_write_value_i & MCAUSE_WMASK;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rv_trap_ctrl.sv
// Bench for rv_trap_ctrl: directed scenarios then random traffic, all checked
// cycle by cycle against a behavioural model of the machine-mode trap rules.
module tb_rv_trap_ctrl;

  localparam logic [31:0] TV = 32'h0000_0008;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        x_stall_i, x_kill_i;
  logic [31:0] x_pc_i;
  logic        d_is_csr_i;
  logic [11:0] d_csr_sel_i;
  logic [31:0] x_csr_write_value_i;
  logic        x_exception_i;
  logic [3:0]  x_exception_cause_i;
  logic        x_is_mret_i;
  logic        irq_i, timer_tick_i;
  logic        x_trap_o, x_mret_o;
  logic [31:0] x_trap_pc_o;
  logic [31:0] csr_mstatus_o, csr_mip_o, csr_mie_o, csr_mepc_o, csr_mcause_o;

  rv_trap_ctrl #(.TRAP_VECTOR(TV), .IRQ_SYNC_STAGES(2)) dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .x_stall_i           (x_stall_i),
    .x_kill_i            (x_kill_i),
    .x_pc_i              (x_pc_i),
    .d_is_csr_i          (d_is_csr_i),
    .d_csr_sel_i         (d_csr_sel_i),
    .x_csr_write_value_i (x_csr_write_value_i),
    .x_exception_i       (x_exception_i),
    .x_exception_cause_i (x_exception_cause_i),
    .x_is_mret_i         (x_is_mret_i),
    .irq_i               (irq_i),
    .timer_tick_i        (timer_tick_i),
    .x_trap_o            (x_trap_o),
    .x_trap_pc_o         (x_trap_pc_o),
    .x_mret_o            (x_mret_o),
    .csr_mstatus_o       (csr_mstatus_o),
    .csr_mip_o           (csr_mip_o),
    .csr_mie_o           (csr_mie_o),
    .csr_mepc_o          (csr_mepc_o),
    .csr_mcause_o        (csr_mcause_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state.
  logic [31:0] m_mstatus, m_mie, m_mepc, m_mcause;
  logic        m_mtip, m_hold;
  logic        m_irq_hist [2];

  logic        obs_trap, obs_mret;
  logic [31:0] obs_pc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mstatus = '0; m_mie = '0; m_mepc = '0; m_mcause = '0;
    m_mtip = 1'b0; m_hold = 1'b0;
    m_irq_hist[0] = 1'b0; m_irq_hist[1] = 1'b0;
  endtask

  task automatic clear_inputs();
    x_stall_i = 0; x_kill_i = 0; x_pc_i = '0; d_is_csr_i = 0; d_csr_sel_i = '0;
    x_csr_write_value_i = '0; x_exception_i = 0; x_exception_cause_i = '0;
    x_is_mret_i = 0; timer_tick_i = 0;
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic step();
    logic        adv, meip, pend, ext, e_trap, e_irq, e_mret, wr;
    logic [31:0] mip, e_pc;
    logic [31:0] n_mstatus, n_mie, n_mepc, n_mcause;
    logic        n_mtip;
    @(negedge clk_i);
    adv  = !x_stall_i && !x_kill_i;
    meip = m_irq_hist[1];
    mip  = (32'(meip) << 11) | (32'(m_mtip) << 7);
    pend = m_mstatus[3] && ((m_mie & mip) != 0) && !m_hold;
    ext  = m_mie[11] && meip;
    e_irq  = adv && !x_exception_i && pend;
    e_trap = (adv && x_exception_i) || e_irq;
    e_mret = adv && !e_trap && x_is_mret_i;
    wr     = adv && !e_trap && !e_mret && d_is_csr_i;
    e_pc   = TV;
`ifdef URV_VECTORED_IRQ_EN
    if (e_irq) e_pc = TV + 4 * (ext ? 11 : 7);
`endif
    chk("mstatus", csr_mstatus_o, m_mstatus);
    chk("mie", csr_mie_o, m_mie);
    chk("mip", csr_mip_o, mip);
    chk("mepc", csr_mepc_o, m_mepc);
    chk("mcause", csr_mcause_o, m_mcause);
    chk("trap", 32'(x_trap_o), 32'(e_trap));
    chk("mret", 32'(x_mret_o), 32'(e_mret));
    if (e_trap) chk("trap_pc", x_trap_pc_o, e_pc);
    obs_trap = x_trap_o; obs_mret = x_mret_o; obs_pc = x_trap_pc_o;

    n_mstatus = m_mstatus; n_mie = m_mie; n_mepc = m_mepc; n_mcause = m_mcause;
    n_mtip = m_mtip;
    if (timer_tick_i) n_mtip = 1'b1;
    else if (wr && d_csr_sel_i == 12'h344) n_mtip = x_csr_write_value_i[7];
    if (e_trap) begin
      n_mepc    = {x_pc_i[31:2], 2'b00};
      n_mcause  = e_irq ? (32'h8000_0000 + (ext ? 11 : 7)) : {28'b0, x_exception_cause_i};
      n_mstatus = m_mstatus[3] ? 32'h80 : 32'h0;
    end else if (e_mret) begin
      n_mstatus = 32'h80 | (m_mstatus[7] ? 32'h8 : 32'h0);
    end else if (wr) begin
      case (d_csr_sel_i)
        12'h300: n_mstatus = x_csr_write_value_i & 32'h88;
        12'h304: n_mie     = x_csr_write_value_i & 32'h880;
        12'h341: n_mepc    = {x_csr_write_value_i[31:2], 2'b00};
        12'h342: n_mcause  = {x_csr_write_value_i[31], 27'b0, x_csr_write_value_i[3:0]};
        default: ;
      endcase
    end
    @(posedge clk_i);
    m_mstatus = n_mstatus; m_mie = n_mie; m_mepc = n_mepc; m_mcause = n_mcause;
    m_mtip = n_mtip;
    if (adv) m_hold = e_trap || e_mret;
    m_irq_hist[1] = m_irq_hist[0];
    m_irq_hist[0] = irq_i;
    #1;
  endtask

  task automatic csr_write(input logic [11:0] sel, input logic [31:0] v);
    d_is_csr_i = 1; d_csr_sel_i = sel; x_csr_write_value_i = v;
    step();
    d_is_csr_i = 0; d_csr_sel_i = '0; x_csr_write_value_i = '0;
  endtask

  logic [11:0] sel_tab [6] = '{12'h300, 12'h304, 12'h341, 12'h342, 12'h344, 12'h305};
  logic [31:0] exp_vec_pc;

  initial begin
    rst_i = 1; irq_i = 0;
    clear_inputs();
    model_reset();
    repeat (3) @(posedge clk_i);
    #1 rst_i = 0;
    chk("rst_mstatus", csr_mstatus_o, 32'h0);
    chk("rst_mcause", csr_mcause_o, 32'h0);

    // External interrupt entry through the synchronizer.
    csr_write(12'h304, 32'h800);
    chk("mie_wr", csr_mie_o, 32'h800);
    csr_write(12'h300, 32'h8);
    irq_i = 1;
    step();
    chk("meip_1clk", csr_mip_o, 32'h0);
    step();
    chk("meip_2clk", csr_mip_o, 32'h800);
    x_pc_i = 32'h1000;
    step();
    chk("ext_trap", 32'(obs_trap), 32'h1);
    chk("ext_mepc", csr_mepc_o, 32'h1000);
    chk("ext_mcause", csr_mcause_o, 32'h8000_000B);
    chk("ext_mstatus", csr_mstatus_o, 32'h80);

    // mret with interrupt still pending.
    x_is_mret_i = 1; step(); x_is_mret_i = 0;
    chk("mret_flag", 32'(obs_mret), 32'h1);
    chk("mret_mstatus", csr_mstatus_o, 32'h88);
    step();
    chk("mret_holdoff", 32'(obs_trap), 32'h0);
    step();
    chk("mret_then_irq", 32'(obs_trap), 32'h1);

    // Exception beats a same-cycle pending interrupt.
    step();
    csr_write(12'h300, 32'h8);
    x_exception_i = 1; x_exception_cause_i = 4'd2; x_pc_i = 32'h2000;
    step();
    x_exception_i = 0; x_exception_cause_i = '0;
    chk("exc_trap", 32'(obs_trap), 32'h1);
    chk("exc_mcause", csr_mcause_o, 32'h2);
    chk("exc_mepc", csr_mepc_o, 32'h2000);
    x_is_mret_i = 1; step(); x_is_mret_i = 0;
    x_pc_i = 32'h3006;
    step();
    chk("exc_defer", 32'(obs_trap), 32'h0);
    step();
    chk("deferred_irq", 32'(obs_trap), 32'h1);
    chk("deferred_mepc", csr_mepc_o, 32'h3004);
    irq_i = 0;
    csr_write(12'h300, 32'h0);
    step(); step();
    chk("meip_clear", csr_mip_o, 32'h0);

    // Sticky timer pending bit.
    timer_tick_i = 1; step(); timer_tick_i = 0;
    chk("mtip_set", csr_mip_o, 32'h80);
    timer_tick_i = 1; csr_write(12'h344, 32'h0); timer_tick_i = 0;
    chk("mtip_tick_wins", csr_mip_o, 32'h80);
    csr_write(12'h344, 32'h0);
    chk("mtip_clear", csr_mip_o, 32'h0);

    // Stall and kill gating on a pending timer interrupt.
    csr_write(12'h304, 32'h80);
    timer_tick_i = 1; step(); timer_tick_i = 0;
    csr_write(12'h300, 32'h8);
    x_pc_i = 32'h4000; x_stall_i = 1;
    step();
    chk("stall_notrap", 32'(obs_trap), 32'h0);
    chk("stall_mepc", csr_mepc_o, 32'h3004);
    x_stall_i = 0; x_kill_i = 1; x_exception_i = 1;
    step();
    chk("kill_notrap", 32'(obs_trap), 32'h0);
    chk("kill_mstatus", csr_mstatus_o, 32'h8);
    x_kill_i = 0; x_exception_i = 0;
    step();
`ifdef URV_VECTORED_IRQ_EN
    exp_vec_pc = 32'h24;
`else
    exp_vec_pc = 32'h8;
`endif
    chk("timer_trap", 32'(obs_trap), 32'h1);
    chk("timer_pc", obs_pc, exp_vec_pc);
    chk("timer_mcause", csr_mcause_o, 32'h8000_0007);
    chk("timer_mepc", csr_mepc_o, 32'h4000);

    // Asynchronous reset in the middle of a cycle.
    #2 rst_i = 1; x_exception_i = 1;
    #1;
    chk("arst_mstatus", csr_mstatus_o, 32'h0);
    chk("arst_mepc", csr_mepc_o, 32'h0);
    chk("arst_mcause", csr_mcause_o, 32'h0);
    chk("arst_mie", csr_mie_o, 32'h0);
    chk("arst_mip", csr_mip_o, 32'h0);
    chk("arst_trap", 32'(x_trap_o), 32'h0);
    chk("arst_mret", 32'(x_mret_o), 32'h0);
    model_reset();
    @(posedge clk_i);
    #1 rst_i = 0; x_exception_i = 0;

    // Random traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      x_stall_i           = ($urandom_range(0, 9) == 0);
      x_kill_i            = ($urandom_range(0, 11) == 0);
      x_pc_i              = $urandom;
      x_exception_i       = ($urandom_range(0, 9) == 0);
      x_exception_cause_i = 4'($urandom_range(0, 15));
      x_is_mret_i         = ($urandom_range(0, 9) == 0);
      d_is_csr_i          = ($urandom_range(0, 2) == 0);
      d_csr_sel_i         = sel_tab[$urandom_range(0, 5)];
      x_csr_write_value_i = $urandom;
      timer_tick_i        = ($urandom_range(0, 14) == 0);
      if ($urandom_range(0, 19) == 0) irq_i = ~irq_i;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
